// File: rtl/grid_pkg.sv
// grid_pkg: shared widths, palette constants, FSM encoding and cell mapping for the 4x4 paint grid.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package grid_pkg;

   localparam int AW = 4;   // color-memory address width (16 cells)
   localparam int DW = 3;   // color width, RGB 1-1-1

   localparam logic [DW-1:0] RED   = 3'b100;
   localparam logic [DW-1:0] GREEN = 3'b010;
   localparam logic [DW-1:0] BLUE  = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PAINT  = 2'd1,
      ST_CLEAR  = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   // Screen layout stores columns right-to-left and rows bottom-to-top:
   // addr = (3-c)*4 + (3-r). For 2-bit fields, 3-x is just ~x.
   function automatic logic [3:0] cell_addr(input logic [1:0] r, input logic [1:0] c);
      return {~c, ~r};
   endfunction

endpackage

// File: rtl/grid_cursor.sv
// grid_cursor: 4x4 cursor (row/column) driven by single-cycle move pulses, with wraparound.
// Latency: a move pulse updates row/col/cursor_addr on the next clock edge.
// Backpressure: none; every pulse is accepted. Opposing pulses on one axis cancel.
// Ports: clk, rst (async active-low), btn_up/down/left/right in; row, col, cursor_addr out.
module grid_cursor #(
   parameter int AW = grid_pkg::AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          btn_up,
   input  logic          btn_down,
   input  logic          btn_left,
   input  logic          btn_right,
   output logic [1:0]    row,
   output logic [1:0]    col,
   output logic [AW-1:0] cursor_addr
);
   import grid_pkg::*;

   // 2-bit arithmetic gives the wrap for free (0-1 -> 3, 3+1 -> 0).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row <= 2'd0;
         col <= 2'd0;
      end else begin
         if (btn_up && !btn_down)
            row <= row - 2'd1;
         else if (btn_down && !btn_up)
            row <= row + 2'd1;

         if (btn_left && !btn_right)
            col <= col - 2'd1;
         else if (btn_right && !btn_left)
            col <= col + 2'd1;
      end
   end

   assign cursor_addr = AW'(cell_addr(row, col));

endmodule

// File: rtl/grid_write_ctrl.sv
// grid_write_ctrl: arbitrates cursor paints and full-grid clears onto the color-memory write port.
// Latency: paint request -> write 1 cycle later; clear -> 16 writes starting 1 cycle later, done on the 17th.
// Backpressure: none; paints arriving while busy park in a one-deep slot (newest wins).
// Ports: clk, rst (async active-low); btn_* move pulses, paint_req/color_sel, clear_req in;
//        wr_addr/wr_data/wr_en memory write port, cursor_addr, busy, done out.
module grid_write_ctrl #(
   parameter int          AW          = grid_pkg::AW,
   parameter int          DW          = grid_pkg::DW,
   parameter logic [DW-1:0] CLEAR_COLOR = {DW{1'b0}}
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          btn_up,
   input  logic          btn_down,
   input  logic          btn_left,
   input  logic          btn_right,
   input  logic          paint_req,
   input  logic [DW-1:0] color_sel,
   input  logic          clear_req,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          wr_en,
   output logic [AW-1:0] cursor_addr,
   output logic          busy,
   output logic          done
);
   import grid_pkg::*;

   state_t        state, state_nxt;
   logic [1:0]    row, col;
   logic [AW-1:0] req_addr;
   logic [3:0]    clr_cnt;
   logic [AW-1:0] act_addr, pend_addr;
   logic [DW-1:0] act_color, pend_color;
   logic          pend_vld;
   logic          clr_pend;

   grid_cursor #(.AW(AW)) u_cursor (
      .clk         (clk),
      .rst         (rst),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .btn_left    (btn_left),
      .btn_right   (btn_right),
      .row         (row),
      .col         (col),
      .cursor_addr (cursor_addr)
   );

   // Address captured for a request is the pre-move cursor: row/col are the
   // register values before this edge applies any simultaneous move pulse.
   assign req_addr = AW'(cell_addr(row, col));

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (clear_req || clr_pend)
               state_nxt = ST_CLEAR;
            else if (paint_req || pend_vld)
               state_nxt = ST_PAINT;
         end
         ST_PAINT:  state_nxt = ST_IDLE;
         ST_CLEAR:  if (clr_cnt == 4'd15) state_nxt = ST_FINISH;
         ST_FINISH: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- datapath: active paint, pending slot, clear counter ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clr_cnt    <= 4'd0;
         act_addr   <= '0;
         act_color  <= '0;
         pend_addr  <= '0;
         pend_color <= '0;
         pend_vld   <= 1'b0;
         clr_pend   <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (clear_req || clr_pend) begin
                  // Clear wins; a simultaneous paint waits for the FINISH cycle.
                  clr_cnt  <= 4'd0;
                  clr_pend <= 1'b0;
                  if (paint_req) begin
                     pend_vld   <= 1'b1;
                     pend_addr  <= req_addr;
                     pend_color <= color_sel;
                  end
               end else if (paint_req) begin
                  // A fresh request supersedes anything older still parked.
                  act_addr  <= req_addr;
                  act_color <= color_sel;
                  pend_vld  <= 1'b0;
               end else if (pend_vld) begin
                  act_addr  <= pend_addr;
                  act_color <= pend_color;
                  pend_vld  <= 1'b0;
               end
            end
            ST_PAINT: begin
               // PAINT is one cycle, so a clear arriving here is remembered
               // rather than dropped; it starts from the following IDLE cycle.
               if (clear_req)
                  clr_pend <= 1'b1;
               if (paint_req) begin
                  pend_vld   <= 1'b1;
                  pend_addr  <= req_addr;
                  pend_color <= color_sel;
               end
            end
            ST_CLEAR: begin
               clr_cnt <= clr_cnt + 4'd1;
               if (paint_req) begin
                  pend_vld   <= 1'b1;
                  pend_addr  <= req_addr;
                  pend_color <= color_sel;
               end
            end
            ST_FINISH: begin
               // The parked paint is written this cycle from the current slot
               // contents; a request arriving now refills the slot.
               pend_vld <= paint_req;
               if (paint_req) begin
                  pend_addr  <= req_addr;
                  pend_color <= color_sel;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- output logic ----------------
   // Outputs decode registered state only, so reset forces them low at once.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state)
         ST_PAINT: begin
            wr_en   = 1'b1;
            wr_addr = act_addr;
            wr_data = act_color;
         end
         ST_CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = AW'(clr_cnt);
            wr_data = CLEAR_COLOR;
            busy    = 1'b1;
         end
         ST_FINISH: begin
            done = 1'b1;
            if (pend_vld) begin
               wr_en   = 1'b1;
               wr_addr = pend_addr;
               wr_data = pend_color;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/grid_write_ctrl.md
GRID_WRITE_CTRL -- requirements
Module: grid_write_ctrl

Interface
REQ-001 SHALL have parameter AW, default 4, meaning color-memory address width (16 cells).
REQ-002 SHALL have parameter DW, default 3, meaning color width (RGB 1-1-1).
REQ-003 SHALL have parameter CLEAR_COLOR, default 3'b000, meaning fill value written by a clear.
REQ-004 SHALL have port clk  input  1  system clock (same 25 MHz domain as the color-memory write port).
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports btn_up, btn_down, btn_left, btn_right  input  1 each  single-cycle cursor-move pulses.
REQ-007 SHALL have port paint_req  input  1  single-cycle request to write color_sel at the cursor cell.
REQ-008 SHALL have port color_sel  input  DW  color for paint requests.
REQ-009 SHALL have port clear_req  input  1  single-cycle request to fill all 16 cells with CLEAR_COLOR.
REQ-010 SHALL have port wr_addr  output  AW  color-memory write address.
REQ-011 SHALL have port wr_data  output  DW  color-memory write data.
REQ-012 SHALL have port wr_en  output  1  color-memory write enable (regwrite).
REQ-013 SHALL have port cursor_addr  output  AW  memory address of the cell under the cursor.
REQ-014 SHALL have port busy  output  1  high while a clear sequence is in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a clear sequence completes.

Function
REQ-016 Cursor SHALL be held as row r (0 top..3 bottom) and column c (0 left..3 right); cursor_addr SHALL equal (3-c)*4 + (3-r), matching the screen cell layout (top-left = 15, bottom-right = 0).
REQ-017 Move pulses SHALL update r/c on the next clock edge and wrap (r=0 with up -> r=3; c=3 with right -> c=0).
REQ-018 Simultaneous up+down SHALL leave r unchanged; simultaneous left+right SHALL leave c unchanged; row and column moves in the same cycle SHALL both apply.
REQ-019 Moves SHALL be accepted in every state, including during a clear.
REQ-020 FSM states SHALL be IDLE, PAINT, CLEAR, FINISH.
REQ-021 IDLE + paint_req (no clear_req) -> PAINT; in PAINT, wr_en=1, wr_addr=cursor_addr and wr_data=color_sel as sampled in the request cycle; PAINT -> IDLE after one cycle.
REQ-022 A move pulse in the same cycle as paint_req SHALL NOT affect the painted address (pre-move cursor used).
REQ-023 IDLE + clear_req -> CLEAR; clear_req SHALL win over a simultaneous paint_req, which SHALL then be held pending.
REQ-024 In CLEAR, wr_en=1 for exactly 16 consecutive cycles with wr_addr = 0,1,...,15 and wr_data = CLEAR_COLOR; busy=1 for those same cycles; after address 15 -> FINISH.
REQ-025 In FINISH, done=1 for one cycle; if a paint is pending, that same cycle SHALL perform the pending write (wr_en=1, latched address/color) and clear the pending flag; FINISH -> IDLE.
REQ-026 A paint_req during PAINT or CLEAR SHALL be latched into a single pending slot (address+color); a later request before service SHALL overwrite the slot.
REQ-027 A pending paint in IDLE (from PAINT) SHALL be serviced as a PAINT on the next cycle.
REQ-028 clear_req during CLEAR or FINISH SHALL be ignored.
REQ-029 When wr_en=0, wr_addr and wr_data SHALL be 0.
REQ-030 Latency: request at edge N -> write at cycle N+1; clear at N -> writes N+1..N+16, done at N+17.

Reset
REQ-031 On rst low, immediately: state IDLE, r=0, c=0 (cursor_addr=15), pending cleared, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
REQ-032 Reset asserted mid-clear SHALL abort the sequence with no further writes and no done pulse.

Structure
REQ-033 A shared package grid_pkg SHALL hold AW, DW, color constants (RED/GREEN/BLUE), the FSM state encoding and the (r,c)->address mapping function.
REQ-034 Cursor logic SHALL be a sub-module grid_cursor (move pulses in, r/c/cursor_addr out).

Verification
REQ-035 Reset, then 1 right + 1 down -> cursor_addr 10; paint_req with color_sel=3'b100 -> wr_en one cycle, addr 10, data 100.
REQ-036 From reset, up once -> cursor_addr 12; left once -> cursor_addr 0 (wrap both axes).
REQ-037 clear_req and paint_req (color 010, cursor 15) same cycle -> 16 writes addr 0..15 data 000, then done with write addr 15 data 010.
REQ-038 paint_req with simultaneous btn_right at cursor 15 -> write addr 15, cursor_addr 11 afterward.
REQ-039 rst low at 8th clear write -> outputs zero immediately, no done; after release, clear_req restarts at addr 0.
REQ-040 up+down and left+right pulsed together -> cursor_addr unchanged, no write.
